// File: rtl/vend_dispense_arbiter_if.sv
// Handshake bundle between the vending front-ends (master) and the shared
// dispense arbiter (slave).
interface vend_dispense_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]   req;
  logic [2*N-1:0] chg_in;
  logic [N-1:0]   ack;
  logic           newspaper;
  logic           change5;
  logic           busy;
  logic [1:0]     grant_id;
  logic           sold_out;

  modport master (
    output req, chg_in,
    input  ack, newspaper, change5, busy, grant_id, sold_out
  );

  modport slave (
    input  req, chg_in,
    output ack, newspaper, change5, busy, grant_id, sold_out
  );
endinterface

// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter sharing one paper dispenser and one 5-cent hopper between N front-ends.
// Optional stock limit: define VEND_DISPENSE_ARBITER_STOCK_COUNT_EN.
module vend_dispense_arbiter #(
  parameter int N          = 2,
  parameter int DISP_CYC   = 2,
  parameter int CHG_CYC    = 1,
  parameter int STOCK_INIT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  vend_dispense_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DISPENSE, CHANGE, GAP, DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [1:0]     rem_q, rem_d;
  logic [1:0]     last_q, last_d;
  logic [1:0]     gid_q, gid_d;
  logic           np_q, np_d;
  logic           ch_q, ch_d;
  logic           busy_q, busy_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           sold_q, sold_d;
  logic           found, can_grant;
  logic [1:0]     win, win_chg;

`ifdef VEND_DISPENSE_ARBITER_STOCK_COUNT_EN
  logic [3:0]     stock_q, stock_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    last_d  = last_q;
    gid_d   = gid_q;
    found   = 1'b0;
    win     = 2'd0;
    win_chg = 2'd0;
`ifdef VEND_DISPENSE_ARBITER_STOCK_COUNT_EN
    stock_d   = stock_q;
    can_grant = (stock_q != 4'd0);
`else
    can_grant = 1'b1;
`endif

    // Search last+1, last+2, ... so the previous winner goes to the back of the line
    for (int off = 1; off <= N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && bus.req[i] && (i == (int'(last_q) + off) % N)) begin
          found   = 1'b1;
          win     = 2'(i);
          win_chg = bus.chg_in[2*i +: 2];
        end
      end
    end

    case (state_q)
      IDLE: if (found && can_grant) begin
        gid_d   = win;
        last_d  = win;
        rem_d   = (win_chg == 2'd3) ? 2'd2 : win_chg;
        cnt_d   = 8'(DISP_CYC - 1);
        state_d = DISPENSE;
`ifdef VEND_DISPENSE_ARBITER_STOCK_COUNT_EN
        stock_d = stock_q - 4'd1;
`endif
      end
      DISPENSE: if (cnt_q == 8'd0) begin
        if (rem_q != 2'd0) begin
          cnt_d   = 8'(CHG_CYC - 1);
          state_d = CHANGE;
        end else begin
          state_d = DONE;
        end
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      CHANGE: if (cnt_q == 8'd0) begin
        rem_d   = rem_q - 2'd1;
        state_d = GAP;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
      GAP: begin
        cnt_d   = 8'(CHG_CYC - 1);
        state_d = (rem_q != 2'd0) ? CHANGE : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Moore outputs decoded from the next state so they land in flops
    np_d   = (state_d == DISPENSE);
    ch_d   = (state_d == CHANGE);
    busy_d = (state_d != IDLE);
    for (int i = 0; i < N; i++) ack_d[i] = (state_d == DONE) && (gid_d == 2'(i));
`ifdef VEND_DISPENSE_ARBITER_STOCK_COUNT_EN
    sold_d = (stock_d == 4'd0);
`else
    sold_d = 1'b0;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      last_q  <= 2'(N - 1);
      gid_q   <= '0;
      np_q    <= 1'b0;
      ch_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      sold_q  <= 1'b0;
`ifdef VEND_DISPENSE_ARBITER_STOCK_COUNT_EN
      stock_q <= 4'(STOCK_INIT);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      np_q    <= np_d;
      ch_q    <= ch_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      sold_q  <= sold_d;
`ifdef VEND_DISPENSE_ARBITER_STOCK_COUNT_EN
      stock_q <= stock_d;
`endif
    end
  end

  assign bus.ack       = ack_q;
  assign bus.newspaper = np_q;
  assign bus.change5   = ch_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = gid_q;
  assign bus.sold_out  = sold_q;
endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed bench: table of single sales plus hand sequences for async reset,
// round-robin under continuous load, and (when enabled) stock exhaustion.
module tb_vend_dispense_arbiter;
`ifdef VEND_DISPENSE_ARBITER_STOCK_COUNT_EN
  localparam int SI = 2;
`else
  localparam int SI = 8;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vend_dispense_arbiter_if #(.N(2)) bus();

  vend_dispense_arbiter #(.N(2), .DISP_CYC(2), .CHG_CYC(1), .STOCK_INIT(SI)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] chg;
    int         gid;
    int         bursts;
    int         lat;
  } vec_t;

  vec_t tbl[6];

  // Starts at a negedge with the arbiter idle; req dropped and chg_in scrambled
  // right after the grant to show both are ignored mid-sale.
  task automatic run_sale(input logic [1:0] r, input logic [3:0] c,
                          output int gid, output int gout, output int np,
                          output int bursts, output int lat, output int overlap);
    logic prev_ch;
    prev_ch = 1'b0;
    gid = -1; gout = -1; np = 0; bursts = 0; lat = 0; overlap = 0;
    bus.req = r;
    bus.chg_in = c;
    @(posedge clock);
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clock);
      if (n == 1) begin
        bus.req = 2'b00;
        bus.chg_in = ~c;
      end
      if (bus.newspaper) np++;
      if (bus.change5 && !prev_ch) bursts++;
      prev_ch = bus.change5;
      if (bus.newspaper && bus.change5) overlap++;
      if (bus.ack != 2'b00) begin
        lat  = n;
        gid  = (bus.ack == 2'b01) ? 0 : (bus.ack == 2'b10) ? 1 : 9;
        gout = int'(bus.grant_id);
      end
    end
    @(negedge clock);
  endtask

  int gid, gout, np, bursts, lat, overlap, seen, g;

  initial begin
    bus.req = 2'b00;
    bus.chg_in = 4'b0000;
    tbl[0] = '{req: 2'b01, chg: 4'b0000, gid: 0, bursts: 0, lat: 3};
    tbl[1] = '{req: 2'b10, chg: 4'b1000, gid: 1, bursts: 2, lat: 7};
    tbl[2] = '{req: 2'b01, chg: 4'b0011, gid: 0, bursts: 2, lat: 7};
    tbl[3] = '{req: 2'b11, chg: 4'b0100, gid: 1, bursts: 1, lat: 5};
    tbl[4] = '{req: 2'b11, chg: 4'b0001, gid: 0, bursts: 1, lat: 5};
    tbl[5] = '{req: 2'b10, chg: 4'b1111, gid: 1, bursts: 2, lat: 7};

    #30;
    chk("rst_newspaper", int'(bus.newspaper), 0);
    chk("rst_change5",   int'(bus.change5),   0);
    chk("rst_busy",      int'(bus.busy),      0);
    chk("rst_ack",       int'(bus.ack),       0);
    chk("rst_grant_id",  int'(bus.grant_id),  0);
    chk("rst_sold_out",  int'(bus.sold_out),  0);
    #10 reset = 1'b0;

`ifdef VEND_DISPENSE_ARBITER_STOCK_COUNT_EN
    for (int k = 0; k < 2; k++) begin
      run_sale(2'b01, 4'b0000, gid, gout, np, bursts, lat, overlap);
      chk("stock_sale_lat", lat, 3);
      chk("stock_sale_np",  np,  2);
    end
    chk("stock_sold_out", int'(bus.sold_out), 1);
    bus.req = 2'b01;
    np = 0; seen = 0; overlap = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clock);
      if (bus.newspaper) np++;
      if (bus.ack != 2'b00) seen++;
      if (bus.busy) overlap++;
    end
    chk("stock_pending_np",   np,      0);
    chk("stock_pending_ack",  seen,    0);
    chk("stock_pending_busy", overlap, 0);
    chk("stock_still_sold",   int'(bus.sold_out), 1);
    bus.req = 2'b00;
`else
    foreach (tbl[i]) begin
      run_sale(tbl[i].req, tbl[i].chg, gid, gout, np, bursts, lat, overlap);
      chk($sformatf("v%0d_ack_id", i),   gid,     tbl[i].gid);
      chk($sformatf("v%0d_grant_id", i), gout,    tbl[i].gid);
      chk($sformatf("v%0d_np_cyc", i),   np,      2);
      chk($sformatf("v%0d_bursts", i),   bursts,  tbl[i].bursts);
      chk($sformatf("v%0d_latency", i),  lat,     tbl[i].lat);
      chk($sformatf("v%0d_overlap", i),  overlap, 0);
      chk($sformatf("v%0d_ack_done", i), int'(bus.ack), 0);
      chk($sformatf("v%0d_idle", i),     int'(bus.busy), 0);
    end
    chk("sold_out_tied", int'(bus.sold_out), 0);

    // Async reset in the middle of a change burst
    bus.req = 2'b01;
    bus.chg_in = 4'b0010;
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clock);
      if (bus.change5) seen = 1;
    end
    chk("mid_change_reached", seen, 1);
    bus.req = 2'b00;
    #1 reset = 1'b1;
    #1;
    chk("arst_newspaper", int'(bus.newspaper), 0);
    chk("arst_change5",   int'(bus.change5),   0);
    chk("arst_busy",      int'(bus.busy),      0);
    chk("arst_ack",       int'(bus.ack),       0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Both requesters busy: each drops for a cycle after its ack, then re-raises
    bus.req = 2'b11;
    bus.chg_in = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      g = -1;
      for (int n = 0; n < 20 && g < 0; n++) begin
        @(negedge clock);
        if (bus.ack == 2'b01) g = 0;
        else if (bus.ack == 2'b10) g = 1;
      end
      chk($sformatf("rr%0d_order", k), g, k % 2);
      chk($sformatf("rr%0d_grant_id", k), int'(bus.grant_id), k % 2);
      if (g >= 0) begin
        bus.req[g] = 1'b0;
        @(negedge clock);
        bus.req[g] = 1'b1;
      end
    end
    bus.req = 2'b00;
    repeat (12) @(negedge clock);
    chk("rr_final_idle", int'(bus.busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/vend_dispense_arbiter.md
Name: vend_dispense_arbiter

Overview:
- Shares one newspaper dispenser mechanism and one 5-cent change hopper between N vending front-ends (vend_ctrl instances).
- Each front-end that has accepted payment raises a request carrying the change owed in 5-cent units.
- The arbiter grants requesters round-robin, sequences the paper-out pulse and then the change pulses, and acks the requester.

Parameters:
- N, 2, number of requesting front-ends (2..4).
- DISP_CYC, 2, cycles the newspaper output is held high per sale (>=1).
- CHG_CYC, 1, cycles the change5 output is held high per 5-cent coin (>=1).
- STOCK_INIT, 8, papers loaded at reset; used only with STOCK_COUNT_EN.

Ports:
- clock  in  1  system clock, rising edge active.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  per-requester sale request, level; held until the matching ack.
- chg_in  in  2N  change owed per requester, 2 bits each, 5-cent units; bits [2i+1:2i] belong to requester i.
- ack  out  N  one-cycle completion pulse to the granted requester.
- newspaper  out  1  dispenser drive.
- change5  out  1  hopper drive; one high burst per 5-cent coin.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  2  index of the current or last granted requester.
- sold_out  out  1  stock exhausted (see Optional Feature).

Behaviour:
- Reset (async, takes effect immediately, including mid-sale):
  - state=IDLE; all outputs 0.
  - Round-robin pointer last=N-1, so requester 0 wins first.
  - Any in-progress sale is abandoned; no ack is issued.
- States: IDLE, DISPENSE, CHANGE, GAP, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit searching last+1, last+2, ... modulo N.
  - On that edge: grant_id <= winner; last <= winner; rem <= chg_in of the winner, with value 3 clamped to 2; cnt <= DISP_CYC-1; go to DISPENSE.
- DISPENSE:
  - newspaper=1.
  - When cnt==0: go to CHANGE if rem!=0 (cnt <= CHG_CYC-1), else go to DONE.
- CHANGE:
  - change5=1.
  - When cnt==0: rem <= rem-1; go to GAP.
- GAP:
  - One cycle, all drives low.
  - Next state: CHANGE if rem!=0, else DONE. This guarantees at least one low cycle between change bursts.
- DONE:
  - ack[grant_id]=1 for exactly one cycle; go to IDLE.
- Outputs are registered (Moore); newspaper and change5 are never high in the same cycle.
- Latency, req sampled high in IDLE at edge k:
  - newspaper high for edges k+1 .. k+DISP_CYC.
  - With change c: DISP_CYC + c*(CHG_CYC+1) cycles from grant to the DONE state.
  - Total grant-to-ack = DISP_CYC + c*(CHG_CYC+1) + 1 cycles.
- Change value is sampled only at grant; changes to chg_in mid-sale are ignored.
- req dropped mid-sale is ignored; the sale completes and ack is still pulsed.
- A requester must drop req in the cycle after ack. Because DONE always returns to IDLE, a requester still high one cycle late is re-granted (legal, counts as a new sale).
- Simultaneous requests: strict round-robin. A requester waits at most N-1 sales.
- busy=0 only in IDLE.

Optional Feature:
- Macro: VEND_DISPENSE_ARBITER_STOCK_COUNT_EN.
- Defined:
  - 4-bit stock counter loaded with STOCK_INIT at reset; decremented on entry to DISPENSE.
  - sold_out = (stock==0), registered.
  - While sold_out, IDLE grants nothing; req bits stay pending and no ack is issued.
- Undefined:
  - No counter; stock is unlimited; sold_out tied to 0.

Test Plan:
- Reset 40 time units, then req=2'b01, chg_in=0 (N=2, DISP_CYC=2) -> newspaper high 2 cycles; ack[0] pulses 3 cycles after grant; change5 never high; grant_id=0.
- req[1] with chg_in[3:2]=2 -> newspaper 2 cycles, then change5 pattern 1,0,1,0; ack[1] 7 cycles after grant.
- req=2'b11 held through acks (each requester drops req one cycle after its ack, then re-raises) -> grant order 0,1,0,1; never two consecutive grants to the same index.
- chg_in=3 on requester 0 -> exactly 2 change5 bursts (clamped).
- reset asserted during CHANGE -> newspaper, change5, busy and ack drop to 0 with no clock edge; after release, requester 0 wins next.
- With STOCK_COUNT_EN and STOCK_INIT=2: three sales requested -> 2 complete; sold_out rises after the 2nd DISPENSE; the 3rd req stays pending with no ack, newspaper stays low, busy=0.
